// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file constants and the writeback request type
package cpu_pkg;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int REG_ZERO_ADDR = 0;
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot grant; WB_ROUND_ROBIN_EN searches from ptr+1, else lowest index wins
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
`ifdef WB_ROUND_ROBIN_EN
  logic found;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign gnt = req & (~req + {{(N-1){1'b0}}, 1'b1});
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NUM_REQ requesters; WB_ROUND_ROBIN_EN enables round-robin
module regfile_wb_arbiter #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  input  logic                               wr_hold,
  output logic                               rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0]          rf_regw,
  output logic [DATA_WIDTH-1:0]              rf_dataw,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id
);
  import cpu_pkg::REG_ZERO_ADDR;
  localparam int GW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] cand, gnt;
  logic [GW-1:0] ptr, gid, gid_q, gid_d;
  logic [REG_ADDR_WIDTH-1:0] sel_addr, regw_q, regw_d;
  logic [DATA_WIDTH-1:0] sel_data, dataw_q, dataw_d;
  logic hs, we_q, we_d;
  assign cand = (rst || wr_hold) ? '0 : req_valid;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(cand),
    .ptr(ptr),
    .gnt(gnt)
  );
  assign req_ready = gnt;
  assign hs = |gnt;
  always_comb begin
    gid = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gid = GW'(i);
        sel_addr = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  // address-0 writes still load regw/dataw/grant_id, only the enable is suppressed
  always_comb begin
    we_d = hs && (sel_addr != REG_ADDR_WIDTH'(REG_ZERO_ADDR));
    regw_d = hs ? sel_addr : regw_q;
    dataw_d = hs ? sel_data : dataw_q;
    gid_d = hs ? gid : gid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      regw_q <= '0;
      dataw_q <= '0;
      gid_q <= '0;
    end else begin
      we_q <= we_d;
      regw_q <= regw_d;
      dataw_q <= dataw_d;
      gid_q <= gid_d;
    end
  end
`ifdef WB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = hs ? gid : ptr_q;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= GW'(NUM_REQ - 1);
    else ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
`else
  assign ptr = GW'(NUM_REQ - 1);
`endif
  assign rf_write_en = we_q;
  assign rf_regw = regw_q;
  assign rf_dataw = dataw_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors plus a cycle-level behavioural model of the writeback arbiter
module tb_regfile_wb_arbiter;
  import cpu_pkg::*;
  localparam int N = 3;
`ifdef WB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, wr_hold = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, fire_s = '0;
  logic [N*4-1:0] req_addr = '0;
  logic [N*8-1:0] req_data = '0;
  logic rf_write_en;
  logic [3:0] rf_regw;
  logic [7:0] rf_dataw;
  logic [1:0] grant_id;
  int vectors = 0, miscompares = 0;
  wb_req_t q[N][$];
  logic [7:0] rf_mem [16];
  int m_last = N - 1, m_gid = 0, mg;
  logic m_we = 1'b0;
  logic [3:0] m_regw = '0;
  logic [7:0] m_data = '0;
  int exp_seq[6];

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wr_hold(wr_hold),
    .rf_write_en(rf_write_en), .rf_regw(rf_regw), .rf_dataw(rf_dataw), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // who should be granted: first valid requester in search order, none under rst or hold
  function automatic int pick(input logic [N-1:0] v, input logic h, input logic r, input int last);
    int s;
    s = RR ? last + 1 : 0;
    if (r || h) return -1;
    for (int k = 0; k < N; k++) if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  initial for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
  always @(posedge clk) if (rf_write_en) rf_mem[rf_regw] <= rf_dataw;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire_s[i]) void'(q[i].pop_front());
      req_valid[i] = q[i].size() > 0;
      if (q[i].size() > 0) begin
        req_addr[i*4 +: 4] = q[i][0].addr;
        req_data[i*8 +: 8] = q[i][0].data;
      end
    end
  end

  always @(negedge clk) begin
    fire_s = req_valid & req_ready;
    mg = pick(req_valid, wr_hold, rst, m_last);
    chk("req_ready", int'(req_ready), mg < 0 ? 0 : (1 << mg));
    chk("rf_write_en", int'(rf_write_en), int'(m_we));
    chk("rf_regw", int'(rf_regw), int'(m_regw));
    chk("rf_dataw", int'(rf_dataw), int'(m_data));
    chk("grant_id", int'(grant_id), m_gid);
    if (rst) begin
      m_we = 1'b0; m_regw = '0; m_data = '0; m_gid = 0; m_last = N - 1;
    end else if (mg >= 0) begin
      m_regw = req_addr[mg*4 +: 4];
      m_data = req_data[mg*8 +: 8];
      m_we = m_regw != 4'd0;
      m_gid = mg;
      m_last = mg;
    end else m_we = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input int a, input int d);
    q[i].push_back({4'(a), 8'(d)});
  endtask

  task automatic wait_fire(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid[i] && req_ready[i]) && n < 30);
    chk($sformatf("fire%0d", i), int'(req_valid[i] && req_ready[i]), 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q[0].size() + q[1].size() + q[2].size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    exp_seq = RR ? '{2, 0, 1, 2, 0, 1} : '{0, 0, 0, 0, 0, 0};
    push(0, 1, 'h10); push(1, 2, 'h20); push(2, 3, 'h30);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_we", int'(rf_write_en), 0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant", int'(req_ready), 1);
    repeat (4) tick();
    push(0, 5, 'hA3);
    wait_fire(0);
    @(negedge clk);
    chk("single_we", int'(rf_write_en), 1);
    chk("single_regw", int'(rf_regw), 5);
    chk("single_dataw", int'(rf_dataw), 'hA3);
    chk("single_gid", int'(grant_id), 0);
    @(negedge clk);
    chk("single_rd", int'(rf_mem[5]), 'hA3);
    push(1, 0, 'hFF);
    wait_fire(1);
    @(negedge clk);
    chk("r0_we", int'(rf_write_en), 0);
    chk("r0_gid", int'(grant_id), 1);
    chk("r0_dataw", int'(rf_dataw), 'hFF);
    @(negedge clk);
    chk("r0_rd", int'(rf_mem[0]), 0);
    for (int k = 0; k < 6; k++) begin
      push(0, 1, 'h40 + k); push(1, 2, 'h50 + k); push(2, 3, 'h60 + k);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_grant", int'(req_ready), 1 << exp_seq[k]);
      if (k > 0) chk("cont_we", int'(rf_write_en), 1);
    end
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(0, 7, 'h11); push(2, 7, 'h22);
    wait_fire(0);
    @(negedge clk);
    chk("conf_ready", int'(req_ready), 4);
    chk("conf_first", int'(rf_dataw), 'h11);
    @(negedge clk);
    chk("conf_second", int'(rf_dataw), 'h22);
    chk("conf_rd1", int'(rf_mem[7]), 'h11);
    @(negedge clk);
    chk("conf_rd2", int'(rf_mem[7]), 'h22);
    for (int k = 0; k < 4; k++) push(1, 9, 'h90 + k);
    wait_fire(1);
    tick();
    wr_hold = 1'b1;
    @(negedge clk);
    chk("hold1_ready", int'(req_ready), 0);
    chk("hold1_we", int'(rf_write_en), 1);
    repeat (2) begin
      @(negedge clk);
      chk("hold_ready", int'(req_ready), 0);
      chk("hold_we", int'(rf_write_en), 0);
    end
    tick();
    wr_hold = 1'b0;
    wait_fire(1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", int'(req_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_we", int'(rf_write_en), 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among NUM_REQ writeback requesters (e.g. ALU, load unit, CSR/move path). Each requester presents an address/data pair with a valid/ready handshake. One request per cycle is granted, registered, and driven onto the register file's write port the following cycle. Writes to register 0 are accepted and discarded, since register 0 is hardwired to zero.

## Interface
Parameters:
- REG_ADDR_WIDTH, 4, register address width; must match the register file
- DATA_WIDTH, 8, register data width; must match the register file
- NUM_REQ, 3, number of writeback requesters (2..8)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester write request
- req_ready  output  NUM_REQ  per-requester grant; handshake completes when valid&&ready
- req_addr  input  NUM_REQ*REG_ADDR_WIDTH  packed destination addresses; requester i at slice [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
- req_data  input  NUM_REQ*DATA_WIDTH  packed write data, same slicing
- wr_hold  input  1  freezes acceptance (debug/stall); all req_ready low while high
- rf_write_en  output  1  to register file write_en
- rf_regw  output  REG_ADDR_WIDTH  to register file regw
- rf_dataw  output  DATA_WIDTH  to register file dataw
- grant_id  output  $clog2(NUM_REQ)  index of requester whose write is on the port this cycle

## Operation
- Each cycle, at most one requester gets req_ready=1. Candidates: req_valid[i]=1, wr_hold=0, rst=0.
- req_ready is combinational from req_valid, the priority state and wr_hold. It never depends on req_ready of another cycle.
- On handshake, address, data and index are captured into the output register.
- The output stage always drains; the register file never back-pressures.
- Address 0: the handshake completes normally, but rf_write_en stays 0 for that write. rf_regw, rf_dataw and grant_id still load.
- No handshake in a cycle: rf_write_en=0 next cycle. rf_regw, rf_dataw and grant_id hold their previous values.
- Two requesters targeting the same address in one cycle: only one is granted. The loser keeps valid and is granted in a later cycle, so its write lands after the winner's.
- Requesters must hold valid, addr and data stable until ready. The arbiter does not check this.
- State: output register and priority pointer only. There is no FSM beyond these.

## Timing
- Handshake in cycle N: rf_write_en=1 in cycle N+1. The register file updates at the end of N+1, and the new value is readable from cycle N+2.
- Throughput: one write per cycle sustained. No bubbles while any valid is high and wr_hold=0.
- Reset values: rf_write_en=0, rf_regw=0, rf_dataw=0, grant_id=0, req_ready=all 0 during rst, priority pointer=NUM_REQ-1 (so requester 0 wins first).
- rst asserted mid-stream:
  - A write captured in the same cycle as rst is lost.
  - rf_write_en is 0 in the cycle after rst.
- wr_hold rising: a write captured in the previous cycle still completes; nothing new is accepted.

## Configuration
- WB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. The search starts at (last_grant+1) mod NUM_REQ.
  - last_grant updates only on a completed handshake, including address-0 writes.
  - No requester waits more than NUM_REQ-1 grants.
- WB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest index wins.
  - The pointer register is not instantiated.
  - Starvation of high indices is permitted.

## Structure
- Shared package cpu_pkg holds:
  - constant REG_ZERO_ADDR = 0
  - typedef wb_req_t: struct of addr and data, sized from the package's REG_ADDR_WIDTH/DATA_WIDTH defaults
- Sub-module rr_arbiter (parameter N):
  - inputs: req vector, pointer
  - output: one-hot grant
  - purely combinational
  - the macro selects pointer-based or fixed-priority search inside it
- Pointer and output registers live in regfile_wb_arbiter.

## Test plan
- Reset: drive rst for 2 cycles with all valids high -> req_ready=0, rf_write_en=0 throughout; after release, requester 0 is granted first.
- Single write: req0 valid, addr 5, data 0xA3, handshake at cycle N -> rf_write_en=1, rf_regw=5, rf_dataw=0xA3, grant_id=0 at N+1; register file data1 with reg1=5 reads 0xA3 at N+2.
- Register 0: req1 writes addr 0, data 0xFF -> req_ready[1]=1, rf_write_en=0 at N+1; register 0 still reads 0.
- Contention, WB_ROUND_ROBIN_EN defined: all three valid continuously to addrs 1, 2, 3 -> grants 0, 1, 2, 0, ...; rf_write_en high every cycle. Without the macro -> requester 0 granted every cycle.
- Same-address conflict: req0 and req2 both write addr 7 (0x11, 0x22) in one cycle, round-robin from reset -> 0x11 written first, then 0x22; final register value 0x22.
- Hold and reset mid-stream: wr_hold high for 3 cycles -> no grants, rf_write_en=0 from the second hold cycle. rst asserted in a cycle where a handshake occurs -> that write never appears on rf_write_en.
